// File: rtl/branch_pkg.sv
// Shared definitions for the ID-stage branch resolver: compare-mode encodings,
// predictor counter constants and the operand-B dependency helper.
package branch_pkg;

  localparam int unsigned CTR_W = 2;
  localparam logic [CTR_W-1:0] CTR_RESET = 2'b01;

  typedef enum logic [3:0] {
    SEL_BEQ  = 4'd0,
    SEL_BNE  = 4'd1,
    SEL_BGEZ = 4'd2,
    SEL_BGTZ = 4'd3,
    SEL_BLTZ = 4'd4,
    SEL_BLEZ = 4'd5,
    SEL_BLT  = 4'd6,
    SEL_BGE  = 4'd7,
    SEL_BLTU = 4'd8,
    SEL_BGEU = 4'd9
  } sel_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_EVAL
  } state_e;

  function automatic logic need_b(input logic [3:0] sel);
    case (sel)
      SEL_BEQ, SEL_BNE, SEL_BLT, SEL_BGE, SEL_BLTU, SEL_BGEU: need_b = 1'b1;
      default:                                                need_b = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/branch_cmp_core.sv
// Combinational branch condition evaluator: operands and mode in, direction
// and reserved-mode flag out.
module branch_cmp_core
  import branch_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       sel,
  output logic             taken,
  output logic             illegal
);

  logic a_neg;
  logic a_zero;

  assign a_neg  = a[WIDTH-1];
  assign a_zero = (a == '0);

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (sel_e'(sel))
      SEL_BEQ:  taken = (a == b);
      SEL_BNE:  taken = (a != b);
      SEL_BGEZ: taken = ~a_neg;
      SEL_BGTZ: taken = ~a_neg & ~a_zero;
      SEL_BLTZ: taken = a_neg;
      SEL_BLEZ: taken = a_neg | a_zero;
      SEL_BLT:  taken = ($signed(a) <  $signed(b));
      SEL_BGE:  taken = ($signed(a) >= $signed(b));
      SEL_BLTU: taken = (a <  b);
      SEL_BGEU: taken = (a >= b);
      default:  illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// ID-stage branch resolver: operand-readiness stall, registered outcome,
// 2-bit saturating predictor table and branch/mispredict statistics.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IDX_W = 6,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  input  logic [3:0]       req_sel,
  input  logic [WIDTH-1:0] req_pc,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             a_ready,
  input  logic             b_ready,
  input  logic             flush,
  output logic             stall,
  output logic             res_valid,
  output logic             res_taken,
  output logic             res_pred,
  output logic             res_mispredict,
  output logic             res_illegal,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int unsigned DEPTH = 1 << IDX_W;

  state_e           state;
  logic [CTR_W-1:0] ctr [DEPTH];
  logic [IDX_W-1:0] idx;
  logic [CTR_W-1:0] ctr_cur;
  logic [CTR_W-1:0] ctr_nxt;
  logic             ready;
  logic             eval;
  logic             cmp_taken;
  logic             cmp_illegal;
  logic             pred;
  logic             mispred;
  logic             unused_pc_bits;

  branch_cmp_core #(.WIDTH(WIDTH)) u_cmp (
    .a       (req_a),
    .b       (req_b),
    .sel     (req_sel),
    .taken   (cmp_taken),
    .illegal (cmp_illegal)
  );

  assign idx            = req_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{req_pc[WIDTH-1:IDX_W+2], req_pc[1:0]};
  assign ready          = a_ready & (b_ready | ~need_b(req_sel));
  assign stall          = req_valid & ~ready & ~flush;
  assign eval           = req_valid & ready & ~flush;

  assign ctr_cur = ctr[idx];
  assign pred    = ctr_cur[1];
  assign mispred = ~cmp_illegal & (cmp_taken != pred);

  always_comb begin
    ctr_nxt = ctr_cur;
    if (cmp_taken) begin
      if (ctr_cur != 2'b11) ctr_nxt = ctr_cur + 2'b01;
    end else begin
      if (ctr_cur != 2'b00) ctr_nxt = ctr_cur - 2'b01;
    end
  end

  // res_valid is the EVAL state itself, so the pulse is registered and lasts one cycle.
  assign res_valid = (state == ST_EVAL);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      res_taken      <= 1'b0;
      res_pred       <= 1'b0;
      res_mispredict <= 1'b0;
      res_illegal    <= 1'b0;
      branch_cnt     <= '0;
      mispred_cnt    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) ctr[i] <= CTR_RESET;
    end else begin
      if (flush || !req_valid) state <= ST_IDLE;
      else if (!ready)         state <= ST_WAIT;
      else                     state <= ST_EVAL;

      if (eval) begin
        res_taken      <= cmp_taken;
        res_pred       <= pred;
        res_mispredict <= mispred;
        res_illegal    <= cmp_illegal;
        branch_cnt     <= branch_cnt + CNT_W'(1);
        if (mispred) mispred_cnt <= mispred_cnt + CNT_W'(1);
        if (!cmp_illegal) ctr[idx] <= ctr_nxt;
      end
    end
  end

endmodule
